// File: rtl/axi_read_burst_streamer.sv
// axi_read_burst_streamer
//   Consumes the AXI4 read-data channel for the full-length INCR bursts issued by the
//   linear read-address generator and re-emits the payload as an AXI-Stream. Surplus
//   beats of the final burst are consumed but not forwarded. The last forwarded beat
//   carries tlast and a trimmed tkeep. Completion and sticky error status are reported
//   for one transfer per start.
//
// Ports
//   aclk, resetn      clock, synchronous active-low reset
//   start, done       start a transfer (accepted while done=1); done=1 means idle
//   dataSizeInBytes   transfer byte count, sampled on an accepted start
//   respError         sticky: some beat had rresp != OKAY
//   lastError         sticky: rlast disagreed with the expected burst boundary
//   rid/rdata/rresp/rlast/rvalid/rready   AXI4 R channel (rid ignored)
//   m_axis_*          AXI-Stream output
module axi_read_burst_streamer #(
    parameter int unsigned DATA_WIDTH               = 64,
    parameter int unsigned ADDR_WIDTH               = 32,
    parameter int unsigned ID_WIDTH                 = 8,
    parameter int unsigned AxLEN_BEATS_PER_TRANSFER = 15
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic                    start,
    output logic                    done,
    input  logic [ADDR_WIDTH-1:0]   dataSizeInBytes,
    output logic                    respError,
    output logic                    lastError,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int unsigned KEEP_W      = DATA_WIDTH / 8;
    localparam int unsigned LOG_BPB     = $clog2(KEEP_W);
    localparam int unsigned BURST_BEATS = AxLEN_BEATS_PER_TRANSFER + 1;
    localparam int unsigned LOG_BEATS   = $clog2(BURST_BEATS);
    localparam int unsigned LOG_BURST   = LOG_BPB + LOG_BEATS;

    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BPB_M1   = ADDR_WIDTH'(KEEP_W - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_M1 = ADDR_WIDTH'(KEEP_W * BURST_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] AXLEN_A  = ADDR_WIDTH'(AxLEN_BEATS_PER_TRANSFER);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t state, state_next;

    // Transfer bookkeeping
    logic [ADDR_WIDTH-1:0] fwd_beats;
    logic [ADDR_WIDTH-1:0] rx_beats;
    logic [ADDR_WIDTH-1:0] beat_idx;
    logic [KEEP_W-1:0]     last_keep;
    logic                  tlast_gone;

    // Output register and skid register
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [KEEP_W-1:0]     out_keep;
    logic                  out_last;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [KEEP_W-1:0]     skid_keep;
    logic                  skid_last;

    // Values loaded on an accepted start
    logic [ADDR_WIDTH-1:0] fwd_load;
    logic [ADDR_WIDTH-1:0] rx_load;
    logic [ADDR_WIDTH-1:0] size_rem;
    logic [KEEP_W-1:0]     keep_load;

    logic                  accept_start;
    logic                  r_hs;
    logic                  fwd_beat;
    logic                  is_last_fwd;
    logic                  out_free;
    logic                  tlast_fire;
    logic                  tlast_gone_next;
    logic [ADDR_WIDTH-1:0] rx_next;
    logic                  skid_valid_next;
    logic                  rready_next;
    logic [KEEP_W-1:0]     new_keep;

    logic unused;
    assign unused = ^rid;

    assign m_axis_tdata  = out_data;
    assign m_axis_tkeep  = out_keep;
    assign m_axis_tlast  = out_last;
    assign m_axis_tvalid = out_valid;

    // Divisions are by powers of two, so ceil() is an add followed by a shift.
    always_comb begin
        fwd_load  = (dataSizeInBytes + BPB_M1) >> LOG_BPB;
        rx_load   = ((dataSizeInBytes + BURST_M1) >> LOG_BURST) << LOG_BEATS;
        size_rem  = dataSizeInBytes & BPB_M1;
        keep_load = (size_rem == '0) ? '1 : ~({KEEP_W{1'b1}} << size_rem);
    end

    always_comb begin
        accept_start    = done && start;
        r_hs            = rvalid && rready;
        fwd_beat        = r_hs && (state == STREAM);
        is_last_fwd     = fwd_beat && (fwd_beats == ONE);
        new_keep        = is_last_fwd ? last_keep : '1;
        out_free        = !out_valid || m_axis_tready;
        tlast_fire      = out_valid && out_last && m_axis_tready;
        tlast_gone_next = tlast_gone || tlast_fire;
        rx_next         = rx_beats - ADDR_WIDTH'(r_hs);
        // rready is issued only when the skid is empty, so a forwarded beat never
        // meets a full skid register.
        skid_valid_next = skid_valid ? !out_free : (fwd_beat && !out_free);

        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept_start && (dataSizeInBytes != '0)) state_next = STREAM;
            end
            STREAM: begin
                // The tlast beat is only just entering the buffer, so completion
                // can never coincide with this transition.
                if (is_last_fwd) state_next = DRAIN;
            end
            DRAIN: begin
                if ((rx_next == '0) && tlast_gone_next) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Registered rready; in DRAIN it also drops once every burst beat has
        // arrived so no beat beyond the transfer is ever taken.
        unique case (state_next)
            STREAM:  rready_next = !skid_valid_next;
            DRAIN:   rready_next = (rx_next != '0);
            default: rready_next = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            done       <= 1'b1;
            rready     <= 1'b0;
            respError  <= 1'b0;
            lastError  <= 1'b0;
            fwd_beats  <= '0;
            rx_beats   <= '0;
            beat_idx   <= '0;
            last_keep  <= '0;
            tlast_gone <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
        end else begin
            done   <= (state_next == IDLE);
            rready <= rready_next;

            if (accept_start) begin
                fwd_beats  <= fwd_load;
                rx_beats   <= rx_load;
                last_keep  <= keep_load;
                beat_idx   <= '0;
                respError  <= 1'b0;
                lastError  <= 1'b0;
                tlast_gone <= 1'b0;
            end else begin
                tlast_gone <= tlast_gone_next;
                if (r_hs) begin
                    rx_beats <= rx_next;
                    // Burst position follows the beat count; rlast is only checked.
                    beat_idx <= (beat_idx == AXLEN_A) ? '0 : beat_idx + ONE;
                    if (rresp != 2'b00) respError <= 1'b1;
                    if (rlast != (beat_idx == AXLEN_A)) lastError <= 1'b1;
                end
                if (fwd_beat) fwd_beats <= fwd_beats - ONE;
            end

            // Two-entry buffer: the skid entry always drains ahead of new beats.
            if (skid_valid) begin
                if (out_free) begin
                    out_data   <= skid_data;
                    out_keep   <= skid_keep;
                    out_last   <= skid_last;
                    skid_valid <= 1'b0;
                end
            end else if (fwd_beat) begin
                if (out_free) begin
                    out_valid <= 1'b1;
                    out_data  <= rdata;
                    out_keep  <= new_keep;
                    out_last  <= is_last_fwd;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= rdata;
                    skid_keep  <= new_keep;
                    skid_last  <= is_last_fwd;
                end
            end else if (out_free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_burst_streamer.sv
module tb_axi_read_burst_streamer;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] size = '0;
    logic          respError;
    logic          lastError;
    logic [IW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axi_read_burst_streamer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ID_WIDTH(IW),
        .AxLEN_BEATS_PER_TRANSFER(15)
    ) dut (
        .aclk(aclk),
        .resetn(resetn),
        .start(start),
        .done(done),
        .dataSizeInBytes(size),
        .respError(respError),
        .lastError(lastError),
        .rid(rid),
        .rdata(rdata),
        .rresp(rresp),
        .rlast(rlast),
        .rvalid(rvalid),
        .rready(rready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] pat(input int k);
        logic [31:0] kk;
        kk = k;
        return {16'hC0DE, kk[15:0], (kk * 32'h0101_0101) ^ 32'h5A5A_5A5A};
    endfunction

    // One transfer: the bench plays the memory (exactly exp_rx beats) and the stream sink.
    task automatic run_xfer(input int sz, input int exp_rx, input int exp_fwd,
                            input logic [7:0] exp_keep, input bit rnd,
                            input int err_idx, input int early_idx, input bit mid_start,
                            input bit exp_resp, input bit exp_last);
        int rx_sent = 0;
        int fwd_rx = 0;
        int s_cnt = 0;
        int cyc = 0;
        int ev_r = -1;
        int ev_t = -1;
        int ev;
        bit stall = 0;
        bit seen_done = 0;
        bit r_pending = 0;
        logic [63:0] pd = '0;
        logic [7:0] pk = '0;
        logic pl = 1'b0;

        @(negedge aclk);
        size  = sz;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("done_low_after_start", done, 0);
        chk("resp_cleared_on_start", respError, 0);
        chk("last_cleared_on_start", lastError, 0);
        chk("rready_after_start", rready, 1);

        for (int t = 0; t < 3000; t++) begin
            cyc++;
            if (stall) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_tdata", m_axis_tdata, pd);
                chk("hold_tkeep", m_axis_tkeep, pk);
                chk("hold_tlast", m_axis_tlast, pl);
            end
            if (fwd_rx < exp_fwd && (fwd_rx - s_cnt) == 2)
                chk("rready_skid_full", rready, 0);
            if (done) begin
                ev = (ev_r > ev_t) ? ev_r : ev_t;
                chk("done_timing", cyc, ev + 1);
                seen_done = 1;
                break;
            end

            start = mid_start && (cyc == 3);
            if (start) size = 8;

            if (!r_pending)
                rvalid = (rx_sent < exp_rx) && (!rnd || ($urandom_range(0, 1) == 1));
            rdata = pat(rx_sent);
            rresp = (rx_sent == err_idx) ? 2'd2 : 2'd0;
            rlast = ((rx_sent % 16) == 15) || (rx_sent == early_idx);
            rid   = rx_sent[7:0];
            m_axis_tready = !rnd || ($urandom_range(0, 1) == 1);

            r_pending = rvalid && !rready;
            if (rvalid && rready) begin
                rx_sent++;
                if (fwd_rx < exp_fwd) fwd_rx++;
                if (rx_sent == exp_rx) ev_r = cyc;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk("stream_data", m_axis_tdata, pat(s_cnt));
                chk("stream_keep", m_axis_tkeep, (s_cnt == exp_fwd - 1) ? exp_keep : 8'hFF);
                chk("stream_last", m_axis_tlast, (s_cnt == exp_fwd - 1) ? 1 : 0);
                if (s_cnt == exp_fwd - 1) ev_t = cyc;
                s_cnt++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pk = m_axis_tkeep;
            pl = m_axis_tlast;
            @(negedge aclk);
        end

        start = 1'b0;
        rvalid = 1'b0;
        m_axis_tready = 1'b1;
        chk("done_seen", seen_done, 1);
        chk("stream_beats", s_cnt, exp_fwd);
        chk("r_beats", rx_sent, exp_rx);
        chk("resp_error", respError, exp_resp);
        chk("last_error", lastError, exp_last);
        chk("rready_idle", rready, 0);
        chk("tvalid_idle", m_axis_tvalid, 0);
    endtask

    initial begin
        int cnt;

        resetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_done", done, 1);
        chk("rst_rready", rready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tkeep", m_axis_tkeep, 8'h00);
        chk("rst_resp", respError, 0);
        chk("rst_last", lastError, 0);
        resetn = 1'b1;

        // 256 B, full throughput; a start pulse mid-transfer must be ignored
        run_xfer(256, 32, 32, 8'hFF, 0, -1, -1, 1, 0, 0);
        // 100 B: 13 forwarded, last keep 0x0F, 3 surplus beats drained
        run_xfer(100, 16, 13, 8'h0F, 0, -1, -1, 0, 0, 0);
        // 512 B with random rvalid and tready
        run_xfer(512, 64, 64, 8'hFF, 1, -1, -1, 0, 0, 0);
        // 129 B: one byte spills into a second burst
        run_xfer(129, 32, 17, 8'h01, 1, -1, -1, 0, 0, 0);
        // 8 B: single forwarded beat, 15 drained
        run_xfer(8, 16, 1, 8'hFF, 0, -1, -1, 0, 0, 0);
        // rresp=SLVERR on beat 5
        run_xfer(128, 16, 16, 8'hFF, 0, 4, -1, 0, 1, 0);
        repeat (3) @(negedge aclk);
        chk("resp_sticky", respError, 1);
        // early rlast on beat 10
        run_xfer(128, 16, 16, 8'hFF, 0, -1, 9, 0, 0, 1);

        // Reset in the middle of a transfer
        @(negedge aclk);
        size  = 512;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        cnt = 0;
        m_axis_tready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (cnt == 7) break;
            rvalid = 1'b1;
            rdata  = pat(cnt);
            rresp  = 2'd0;
            rlast  = 1'b0;
            if (rready) cnt++;
            @(negedge aclk);
        end
        chk("rst_reach_beat7", cnt, 7);
        resetn = 1'b0;
        rvalid = 1'b0;
        @(negedge aclk);
        chk("midrst_done", done, 1);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_rready", rready, 0);
        chk("midrst_tkeep", m_axis_tkeep, 8'h00);
        resetn = 1'b1;

        // size 0 start: nothing happens
        @(negedge aclk);
        size  = 0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk("zero_done", done, 1);
            chk("zero_rready", rready, 0);
            @(negedge aclk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
